// File: rtl/mem_bus_if.sv
// Memory-side bus stage: turns control-unit RAM strobes into a single-master
// waitrequest bus transaction, captures read data and formats load results.
module mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_read_en_i,
  input  logic              ram_write_en_i,
  input  logic [3:0]        ram_byte_en_i,
  input  logic              ram_addr_sel_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rt_old_i,
  input  logic [5:0]        opcode_i,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [3:0]        byteenable_o,
  output logic [DATA_W-1:0] writedata_o,
  input  logic              waitrequest_i,
  input  logic [DATA_W-1:0] readdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_word_o,
  output logic [DATA_W-1:0] load_result_o,
  output logic              rdata_valid_o,
  output logic              addr_err_o
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_bus_if: DATA_W must be 32");
  end

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {IDLE = 1'b0, RDATA = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic              capture_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        st_off;
  logic              rd_accept;
  logic              any_accept;
  logic              misaligned;
  logic [31:0]       rdata_word_reg;
  logic              rdata_valid_reg;
  logic              addr_err_reg;

  // Request path is purely combinational; reset masks the strobes.
  assign sel_addr     = ram_addr_sel_i ? data_addr_i : pc_i;
  assign st_off       = sel_addr[1:0];
  assign address_o    = {sel_addr[ADDR_W-1:2], 2'b00};
  assign write_o      = rst_n & ram_write_en_i;
  assign read_o       = rst_n & ram_read_en_i & ~ram_write_en_i;
  assign byteenable_o = ram_byte_en_i;
  assign stall_o      = (read_o | write_o) & waitrequest_i;
  assign rd_accept    = read_o & ~waitrequest_i;
  assign any_accept   = (read_o | write_o) & ~waitrequest_i;

  always_comb begin
    writedata_o = store_data_i;
    case (opcode_i)
      OP_SB:   writedata_o = {4{store_data_i[7:0]}};
      OP_SH:   writedata_o = {2{store_data_i[15:0]}};
      default: writedata_o = store_data_i;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (ram_addr_sel_i) begin
      case (opcode_i)
        OP_LW, OP_SW:         misaligned = (st_off != 2'b00);
        OP_LH, OP_LHU, OP_SH: misaligned = st_off[0];
        default:              misaligned = 1'b0;
      endcase
    end else begin
      misaligned = (pc_i[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = rd_accept ? RDATA : IDLE;
      RDATA:   state_next = rd_accept ? RDATA : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_reg == RDATA);
  end

  // Captured word and valid pulse appear together after the RDATA edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_word_reg  <= '0;
      rdata_valid_reg <= 1'b0;
      addr_err_reg    <= 1'b0;
    end else begin
      rdata_valid_reg <= capture_en;
      if (capture_en) rdata_word_reg <= readdata_i;
      if ((any_accept & misaligned) | (ram_read_en_i & ram_write_en_i))
        addr_err_reg <= 1'b1;
    end
  end

  assign rdata_word_o  = rdata_word_reg;
  assign rdata_valid_o = rdata_valid_reg;
  assign addr_err_o    = addr_err_reg;

  logic [1:0]  ld_off;
  logic [1:0]  lwl_shift;
  logic [31:0] byte_shifted;
  logic [15:0] half_sel;

  assign ld_off       = data_addr_i[1:0];
  assign lwl_shift    = 2'd3 - ld_off;
  assign byte_shifted = rdata_word_reg >> {ld_off, 3'b000};
  assign half_sel     = ld_off[1] ? rdata_word_reg[31:16] : rdata_word_reg[15:0];

  always_comb begin
    load_result_o = rdata_word_reg;
    case (opcode_i)
      OP_LB:  load_result_o = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      OP_LBU: load_result_o = {24'h0, byte_shifted[7:0]};
      OP_LH:  load_result_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_result_o = {16'h0, half_sel};
      OP_LW:  load_result_o = rdata_word_reg;
      OP_LWL: load_result_o = (rdata_word_reg << {lwl_shift, 3'b000}) |
                              (rt_old_i & (32'h00FF_FFFF >> {ld_off, 3'b000}));
      OP_LWR: load_result_o = byte_shifted |
                              (rt_old_i & ~(32'hFFFF_FFFF >> {ld_off, 3'b000}));
      default: load_result_o = rdata_word_reg;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: a byte-level behavioural model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_read_en_i, ram_write_en_i, ram_addr_sel_i;
  logic [3:0]  ram_byte_en_i;
  logic [31:0] pc_i, data_addr_i, store_data_i, rt_old_i;
  logic [5:0]  opcode_i;
  logic [31:0] address_o;
  logic        read_o, write_o;
  logic [3:0]  byteenable_o;
  logic [31:0] writedata_o;
  logic        waitrequest_i;
  logic [31:0] readdata_i;
  logic        stall_o;
  logic [31:0] rdata_word_o, load_result_o;
  logic        rdata_valid_o, addr_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_read_en_i(ram_read_en_i), .ram_write_en_i(ram_write_en_i),
    .ram_byte_en_i(ram_byte_en_i), .ram_addr_sel_i(ram_addr_sel_i),
    .pc_i(pc_i), .data_addr_i(data_addr_i), .store_data_i(store_data_i),
    .rt_old_i(rt_old_i), .opcode_i(opcode_i),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .byteenable_o(byteenable_o), .writedata_o(writedata_o),
    .waitrequest_i(waitrequest_i), .readdata_i(readdata_i),
    .stall_o(stall_o), .rdata_word_o(rdata_word_o),
    .load_result_o(load_result_o), .rdata_valid_o(rdata_valid_o),
    .addr_err_o(addr_err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result built lane by lane from the byte view of the word.
  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [1:0] off,
                                           input logic [31:0] w, input logic [31:0] rt);
    logic [7:0] wb [4];
    logic [7:0] rb [4];
    logic [7:0] ob [4];
    logic [7:0] b;
    logic [15:0] h;
    int o;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = rt[8*i +: 8];
      ob[i] = 8'h00;
    end
    b = wb[o];
    h = {wb[2*(o/2)+1], wb[2*(o/2)]};
    case (op)
      6'h20: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      6'h24: return {24'h0, b};
      6'h21: return h[15] ? {16'hFFFF, h} : {16'h0, h};
      6'h25: return {16'h0, h};
      6'h22: begin
        for (int i = 0; i < 4; i++) begin
          if (i >= 3 - o) ob[i] = wb[i - (3 - o)];
          else            ob[i] = rb[i];
        end
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      6'h26: begin
        for (int i = 0; i < 4; i++) begin
          if (i + o <= 3) ob[i] = wb[i + o];
          else            ob[i] = rb[i];
        end
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      6'h28:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      6'h29:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic exp_misal(input logic sel, input logic [5:0] op,
                                     input logic [31:0] da, input logic [31:0] pc);
    if (!sel) return (pc % 4) != 0;
    if (op == 6'h23 || op == 6'h2B) return (da % 4) != 0;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return (da % 2) != 0;
    return 1'b0;
  endfunction

  // Model state: a read accepted on one edge delivers its word on the next.
  logic        m_pending, m_valid, m_err;
  logic [31:0] m_word;
  logic        m_rd, m_wr;

  assign m_wr = rst_n & ram_write_en_i;
  assign m_rd = rst_n & ram_read_en_i & ~ram_write_en_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
      m_word    <= 32'h0;
      m_err     <= 1'b0;
    end else begin
      m_valid   <= m_pending;
      if (m_pending) m_word <= readdata_i;
      m_pending <= m_rd & ~waitrequest_i;
      if (((m_rd | m_wr) & ~waitrequest_i &
           exp_misal(ram_addr_sel_i, opcode_i, data_addr_i, pc_i)) ||
          (ram_read_en_i && ram_write_en_i))
        m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] sa;
    sa = ram_addr_sel_i ? data_addr_i : pc_i;
    check("address",    address_o,     sa & 32'hFFFF_FFFC);
    check("read",       {31'h0, read_o},  {31'h0, m_rd});
    check("write",      {31'h0, write_o}, {31'h0, m_wr});
    check("byteenable", {28'h0, byteenable_o}, {28'h0, ram_byte_en_i});
    check("writedata",  writedata_o,   exp_wdata(opcode_i, store_data_i));
    check("stall",      {31'h0, stall_o}, {31'h0, (m_rd | m_wr) & waitrequest_i});
    check("rdata_word", rdata_word_o,  m_word);
    check("rdata_valid",{31'h0, rdata_valid_o}, {31'h0, m_valid});
    check("addr_err",   {31'h0, addr_err_o}, {31'h0, m_err});
    check("load_result",load_result_o, exp_load(opcode_i, data_addr_i[1:0], m_word, rt_old_i));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ram_read_en_i  = 1'b0;
    ram_write_en_i = 1'b0;
    ram_byte_en_i  = 4'h0;
    ram_addr_sel_i = 1'b0;
    pc_i           = 32'h0;
    data_addr_i    = 32'h0;
    store_data_i   = 32'h0;
    rt_old_i       = 32'h0;
    opcode_i       = 6'h0;
    waitrequest_i  = 1'b0;
    readdata_i     = 32'h0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_stall", {31'h0, stall_o}, 32'h0);
    check("reset_word", rdata_word_o, 32'h0);
    ram_read_en_i = 1'b1;
    #1;
    check("reset_read_masked", {31'h0, read_o}, 32'h0);
    ram_read_en_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Fetch stalled for three cycles, then accepted.
    ram_read_en_i = 1'b1; pc_i = 32'hBFC0_0000; ram_byte_en_i = 4'hF;
    waitrequest_i = 1'b1; readdata_i = 32'h3C01_1234;
    #1;
    check("fetch_stall", {31'h0, stall_o}, 32'h1);
    check("fetch_addr", address_o, 32'hBFC0_0000);
    step(); step(); step();
    waitrequest_i = 1'b0;
    step();
    ram_read_en_i = 1'b0;
    #1;
    check("fetch_valid_not_yet", {31'h0, rdata_valid_o}, 32'h0);
    step();
    check("fetch_valid", {31'h0, rdata_valid_o}, 32'h1);
    check("fetch_word", rdata_word_o, 32'h3C01_1234);
    step();

    // LB / LBU at byte offset 3.
    ram_read_en_i = 1'b1; ram_addr_sel_i = 1'b1; data_addr_i = 32'h0000_1003;
    opcode_i = 6'h20; ram_byte_en_i = 4'b1000; readdata_i = 32'h80FF_0000;
    #1;
    check("lb_be", {28'h0, byteenable_o}, 32'h8);
    check("lb_addr", address_o, 32'h0000_1000);
    step();
    ram_read_en_i = 1'b0;
    step();
    check("lb_result", load_result_o, 32'hFFFF_FF80);
    opcode_i = 6'h24;
    #1;
    check("lbu_result", load_result_o, 32'h0000_0080);
    step();

    // SH replicates the half and never enters the read-data state.
    ram_write_en_i = 1'b1; data_addr_i = 32'h0000_2002; opcode_i = 6'h29;
    store_data_i = 32'hAAAA_BEEF; ram_byte_en_i = 4'b1100;
    #1;
    check("sh_wdata", writedata_o, 32'hBEEF_BEEF);
    check("sh_addr", address_o, 32'h0000_2000);
    check("sh_write", {31'h0, write_o}, 32'h1);
    step();
    ram_write_en_i = 1'b0;
    step();
    check("sh_no_rdata", {31'h0, rdata_valid_o}, 32'h0);
    check("sh_no_err", {31'h0, addr_err_o}, 32'h0);

    // LWR then LWL at offset 1 with a merge source.
    ram_read_en_i = 1'b1; data_addr_i = 32'h0000_3001; opcode_i = 6'h26;
    rt_old_i = 32'hDDCC_BBAA; readdata_i = 32'h4433_2211; ram_byte_en_i = 4'hF;
    step();
    ram_read_en_i = 1'b0;
    step();
    check("lwr_result", load_result_o, 32'hDD44_3322);
    opcode_i = 6'h22;
    #1;
    check("lwl_result", load_result_o, 32'h2211_BBAA);
    step();

    // Back-to-back reads: second accepted during the first one's data cycle.
    ram_read_en_i = 1'b1; data_addr_i = 32'h0000_4000; opcode_i = 6'h23;
    readdata_i = 32'h1111_1111;
    step();
    readdata_i = 32'h1111_1111;
    step();
    check("b2b_first", rdata_word_o, 32'h1111_1111);
    ram_read_en_i = 1'b0; readdata_i = 32'h2222_2222;
    step();
    check("b2b_second", rdata_word_o, 32'h2222_2222);
    check("b2b_valid", {31'h0, rdata_valid_o}, 32'h1);
    step();

    // Misaligned LW sets the sticky error.
    ram_read_en_i = 1'b1; data_addr_i = 32'h0000_1002; opcode_i = 6'h23;
    readdata_i = 32'h5555_6666;
    #1;
    check("lw_err_before", {31'h0, addr_err_o}, 32'h0);
    step();
    check("lw_err_after", {31'h0, addr_err_o}, 32'h1);
    data_addr_i = 32'h0000_1004;
    step();
    ram_read_en_i = 1'b0;
    step();
    check("err_sticky", {31'h0, addr_err_o}, 32'h1);

    // Aligned read, then reset asserted in the middle of its data cycle.
    ram_read_en_i = 1'b1; readdata_i = 32'h7777_8888;
    step();
    ram_read_en_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_word", rdata_word_o, 32'h0);
    check("rst_err", {31'h0, addr_err_o}, 32'h0);
    check("rst_valid", {31'h0, rdata_valid_o}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("post_rst_word", rdata_word_o, 32'h0);

    // Simultaneous read and write: write wins and the error is flagged.
    ram_read_en_i = 1'b1; ram_write_en_i = 1'b1; data_addr_i = 32'h0000_5000;
    opcode_i = 6'h2B; store_data_i = 32'h1234_5678;
    #1;
    check("rw_read", {31'h0, read_o}, 32'h0);
    check("rw_write", {31'h0, write_o}, 32'h1);
    step();
    check("rw_err", {31'h0, addr_err_o}, 32'h1);
    clear_inputs();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Memory-side stage directly downstream of the CPU control unit.
- Converts the control unit's RAM strobes (read/write enable, byte enables, address select) into a single-master bus transaction with waitrequest.
- Generates the CPU-wide stall, captures read data into a holding register, and formats load results (byte/half extraction, sign/zero extension, LWL/LWR merge) for the register-file write port.
- Flags misaligned accesses.

Parameters:
- ADDR_W, 32, bus/CPU address width.
- DATA_W, 32, bus data width; only 32 is supported, and any other value is an elaboration error.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ram_read_en_i  in  1  read request from control
- ram_write_en_i  in  1  write request from control
- ram_byte_en_i  in  4  lane enables from control
- ram_addr_sel_i  in  1  0 = use pc_i (fetch), 1 = use data_addr_i
- pc_i  in  32  current PC
- data_addr_i  in  32  effective address from ALU
- store_data_i  in  32  rt value for stores
- rt_old_i  in  32  current rt value for LWL/LWR merge
- opcode_i  in  6  current instruction opcode
- address_o  out  32  word-aligned bus address
- read_o  out  1  bus read strobe
- write_o  out  1  bus write strobe
- byteenable_o  out  4  bus lane enables
- writedata_o  out  32  lane-aligned store data
- waitrequest_i  in  1  bus not accepting this cycle
- readdata_i  in  32  bus read data
- stall_o  out  1  stall to CPU
- rdata_word_o  out  32  raw captured word (instruction register source)
- load_result_o  out  32  formatted load value for regfile
- rdata_valid_o  out  1  one-cycle pulse when a new word is captured
- addr_err_o  out  1  sticky misaligned-access flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM to IDLE; rdata_word_o = 0, rdata_valid_o = 0, addr_err_o = 0, stall_o = 0.
  - read_o and write_o are forced 0 while reset is asserted.
- Request path is combinational, with no added latency:
  - address_o = {sel_addr[31:2], 2'b00}, where sel_addr = ram_addr_sel_i ? data_addr_i : pc_i.
  - read_o = ram_read_en_i, write_o = ram_write_en_i, byteenable_o = ram_byte_en_i.
  - read and write both high in one cycle is illegal: write wins, and addr_err_o is set.
- Store alignment, with off = sel_addr[1:0]:
  - SB: writedata_o = {4{store_data_i[7:0]}}.
  - SH: writedata_o = {2{store_data_i[15:0]}}.
  - SW: writedata_o = store_data_i.
  - Lane selection is done purely by byteenable_o.
- FSM states:
  - IDLE: on read_o & ~waitrequest_i, go to RDATA; on write_o & ~waitrequest_i, stay in IDLE (write complete).
  - RDATA: readdata_i is valid this cycle (fixed read latency 1). Capture it into rdata_word_o and pulse rdata_valid_o. If a new read is accepted in the same cycle, stay in RDATA; otherwise go to IDLE.
- Stall:
  - stall_o = (read_o | write_o) & waitrequest_i.
  - While stalled, the CPU holds all inputs stable; the block relies on this and does not latch request fields.
- Load formatting (combinational from rdata_word_o, with off = data_addr_i[1:0]; little-endian lanes, byte k = bits [8k+7:8k]):
  - LB: sign-extend byte off. LBU: zero-extend byte off.
  - LH: sign-extend half off[1]. LHU: zero-extend half off[1].
  - LW: full word.
  - LWL: (word << 8*(3-off)) | (rt_old_i & low (3-off) bytes mask).
  - LWR: (word >> 8*off) | (rt_old_i & high off bytes mask).
  - Other opcodes: load_result_o = rdata_word_o.
- Misalignment:
  - On an accepted data access (ram_addr_sel_i = 1), set addr_err_o if LW/SW has off != 0, or LH/LHU/SH has off[0] != 0.
  - A fetch is misaligned if pc_i[1:0] != 0.
  - addr_err_o is sticky until reset. The access is still issued.
- Reset mid-transaction: any pending RDATA capture is abandoned, and rdata_word_o stays 0 until the next completed read.

Test Plan:
- Fetch with pc_i = 0xBFC00000, waitrequest_i held high for 3 cycles:
  - read_o = 1 and stall_o = 1 for those 3 cycles.
  - One cycle after accept, rdata_valid_o pulses and rdata_word_o = readdata_i = 0x3C011234.
- LB at data_addr_i = 0x1003 with word 0x80FF_0000:
  - byteenable_o = 4'b1000 (control input).
  - load_result_o = 0xFFFFFF80; LBU gives 0x00000080.
- SH with data_addr_i = 0x2002 and store_data_i = 0xAAAA_BEEF:
  - writedata_o = 0xBEEFBEEF, address_o = 0x2000, write_o completes with no RDATA state.
- LWR at off = 1, word 0x44332211, rt_old_i = 0xDDCCBBAA:
  - load_result_o = 0xDD443322.
- LWL at off = 1, same word and rt_old_i:
  - load_result_o = 0x2211BBAA.
- LW at 0x1002:
  - addr_err_o rises after the accept edge and stays high through later aligned accesses.
  - rst_n low mid-RDATA clears addr_err_o and rdata_word_o asynchronously.
